// File: rtl/oled_i2c_writer.sv
// Writes one 3-byte I2C frame {addr, ctrl, payload} per accepted request.
// Each quarter of an SCL period lasts QTR_DIV+1 clocks. SDA is open-drain,
// and the bus outputs are registered so that o_scl and io_sda do not glitch.
module oled_i2c_writer #(
  parameter int QTR_DIV = 31
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        i_req,
  input  logic [23:0] i_data,
  output logic        o_write_done,
  output logic        o_busy,
  output logic        o_ack_err,
  output logic        o_scl,
  inout  wire         io_sda
);

  localparam int CW = (QTR_DIV > 0) ? $clog2(QTR_DIV + 1) : 1;
  localparam logic [CW-1:0] QMAX = CW'(QTR_DIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qidx_q, qidx_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   shreg_q, shreg_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          scl_q, oe_q;
  logic [1:0]    drv_d;
  logic          qend;

  // Bus levels for a given state/quarter: returns {scl, sda_pull_low}.
  function automatic logic [1:0] bus_drive(input state_t s, input logic [1:0] q,
                                           input logic b);
    case (s)
      S_START: bus_drive = {1'b1, (q == 2'd1)};
      S_BIT:   bus_drive = {q[1], ~b};
      S_ACK:   bus_drive = {q[1], 1'b0};
      S_STOP: begin
        case (q)
          2'd0:    bus_drive = 2'b01;
          2'd1:    bus_drive = 2'b11;
          default: bus_drive = 2'b10;
        endcase
      end
      default: bus_drive = 2'b10;
    endcase
  endfunction

  assign qend = (qcnt_q == QMAX);

  // Next-state logic: frame sequencing, quarter timing, shifting and ACK sampling.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    qidx_d  = qidx_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (state_q inside {S_START, S_BIT, S_ACK, S_STOP})
      qcnt_d = qend ? '0 : qcnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          shreg_d = i_data;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          qcnt_d  = '0;
          qidx_d  = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (qend) begin
          qidx_d = (qidx_q == 2'd1) ? 2'd0 : qidx_q + 2'd1;
          if (qidx_q == 2'd1) state_d = S_BIT;
        end
      end
      S_BIT: begin
        if (qend) begin
          qidx_d = qidx_q + 2'd1;
          if (qidx_q == 2'd3) begin
            shreg_d = {shreg_q[22:0], 1'b0};
            if (bit_q == 3'd7) begin
              bit_d   = 3'd0;
              state_d = S_ACK;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
      end
      S_ACK: begin
        // A released (high) SDA at the end of the first high quarter is a NACK.
        if (qend && qidx_q == 2'd2 && io_sda === 1'b1) err_d = 1'b1;
        if (qend) begin
          qidx_d = qidx_q + 2'd1;
          if (qidx_q == 2'd3) begin
            if (byte_q == 2'd2) begin
              byte_d  = 2'd0;
              state_d = S_STOP;
            end else begin
              byte_d  = byte_q + 2'd1;
              state_d = S_BIT;
            end
          end
        end
      end
      S_STOP: begin
        if (qend) begin
          qidx_d = (qidx_q == 2'd2) ? 2'd0 : qidx_q + 2'd1;
          if (qidx_q == 2'd2) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        qcnt_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    drv_d = bus_drive(state_d, qidx_d, shreg_d[23]);
  end

  // State and output registers; reset aborts any frame with the bus released.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      qidx_q  <= 2'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      shreg_q <= 24'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      qidx_q  <= qidx_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
      scl_q   <= drv_d[1];
      oe_q    <= drv_d[0];
    end
  end

  assign o_write_done = done_q;
  assign o_busy       = busy_q;
  assign o_ack_err    = err_q;
  assign o_scl        = scl_q;
  assign io_sda       = oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_oled_i2c_writer.sv
// Bench for oled_i2c_writer: directed and random frames, an I2C bus decoder
// with an ACK/NACK slave, frame timing, back-to-back and mid-frame reset.
module tb_oled_i2c_writer;

  localparam int Q     = 3;
  localparam int QC    = Q + 1;
  localparam int FRAME = 113 * QC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [23:0] i_data = 24'd0;
  logic        o_write_done, o_busy, o_ack_err, o_scl;
  logic        slave_low = 1'b0;
  wire         io_sda;

  pullup (io_sda);
  assign io_sda = slave_low ? 1'b0 : 1'bz;

  oled_i2c_writer #(.QTR_DIV(Q)) dut (
    .clk_50m(clk), .rst(rst), .i_req(i_req), .i_data(i_data),
    .o_write_done(o_write_done), .o_busy(o_busy), .o_ack_err(o_ack_err),
    .o_scl(o_scl), .io_sda(io_sda)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: expected bytes in bus order, plus which byte the slave NACKs (3 = none).
  logic [7:0] exp_q[$];
  int nack_sel = 3;
  int frames_ok = 0;

  task automatic push_exp(input logic [23:0] d);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  // Bus decoder / slave / protocol checker.
  int dec_byte = 0, dec_bit = 0, start_cnt = 0, stop_cnt = 0, done_cnt = 0;
  int hi_len = 0, lo_len = 0;
  bit in_frame = 0, ack_pend = 0, nacked = 0, hi_valid = 0, lo_valid = 0;
  logic pscl = 1'b1, psda = 1'b1;
  logic [7:0] shv = 8'd0;

  initial forever begin
    @(negedge clk);
    if (o_write_done) done_cnt++;
    if (rst) begin
      in_frame = 0; dec_byte = 0; dec_bit = 0; ack_pend = 0;
      hi_valid = 0; lo_valid = 0; slave_low = 1'b0;
    end else if (!pscl && o_scl) begin
      if (lo_valid) chk("scl_low_len", 32'(lo_len), 32'((dec_byte == 3) ? QC : 2 * QC));
      lo_valid = 0; hi_len = 1; hi_valid = in_frame;
      if (in_frame && dec_byte < 3) begin
        if (dec_bit < 8) begin
          shv = {shv[6:0], io_sda};
          dec_bit++;
        end else begin
          if (exp_q.size() == 0) chk("byte_unexpected", 32'(shv), 32'hFFFF_FFFF);
          else chk("byte", 32'(shv), 32'(exp_q.pop_front()));
          if (io_sda) nacked = 1;
          ack_pend = 1; dec_byte++; dec_bit = 0;
        end
      end
    end else if (pscl && !o_scl) begin
      if (hi_valid) chk("scl_high_len", 32'(hi_len), 32'(2 * QC));
      hi_valid = 0; lo_len = 1; lo_valid = in_frame;
      if (ack_pend) begin
        chk("ack_err_at_ack", 32'(o_ack_err), 32'(nacked));
        ack_pend = 0;
      end
      slave_low = in_frame && dec_bit == 8 && nack_sel != dec_byte;
    end else if (o_scl) begin
      hi_len++;
      if (psda && !io_sda) begin
        chk("start_outside_frame", 32'(in_frame), 32'd0);
        in_frame = 1; dec_byte = 0; dec_bit = 0; nacked = 0; hi_valid = 0;
        start_cnt++;
      end else if (!psda && io_sda) begin
        chk("stop_after_3_bytes", 32'(dec_byte), 32'd3);
        in_frame = 0; hi_valid = 0;
        stop_cnt++;
      end
    end else begin
      lo_len++;
    end
    pscl = o_scl;
    psda = io_sda;
  end

  task automatic wait_accept(output int acc);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (!o_busy && n < 50);
    chk("accept_seen", 32'(o_busy), 32'd1);
    acc = cyc;
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (!o_write_done && n < FRAME + 50);
    chk("done_seen", 32'(o_write_done), 32'd1);
    dc = cyc;
  endtask

  task automatic run_frame(input logic [23:0] d, input int nk);
    int acc, dc;
    nack_sel = nk; i_data = d; i_req = 1'b1;
    wait_accept(acc);
    i_req = 1'b0;
    push_exp(d);
    chk("err_clear_on_accept", 32'(o_ack_err), 32'd0);
    i_data = 24'($urandom);
    wait_done(dc);
    chk("latency", 32'(dc - acc), 32'(FRAME));
    chk("ack_err_end", 32'(o_ack_err), 32'(nk < 3));
    chk("busy_in_done", 32'(o_busy), 32'd1);
    chk("bytes_consumed", 32'(exp_q.size()), 32'd0);
    @(negedge clk); #1;
    chk("done_one_cycle", 32'(o_write_done), 32'd0);
    chk("busy_drop", 32'(o_busy), 32'd0);
    chk("ack_err_sticky", 32'(o_ack_err), 32'(nk < 3));
    frames_ok++;
  endtask

  initial begin
    int a1, a2, d1, d2, n, d0;
    logic [23:0] rd;
    #2 rst = 1'b1;
    #1;
    chk("rst_scl", 32'(o_scl), 32'd1);
    chk("rst_sda", 32'(io_sda), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_write_done), 32'd0);
    chk("rst_err", 32'(o_ack_err), 32'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("idle_scl", 32'(o_scl), 32'd1);
    chk("idle_sda", 32'(io_sda), 32'd1);

    run_frame(24'h7800AE, 3);

    // Back-to-back: request held, data switched on the done cycle.
    nack_sel = 3; rd = 24'($urandom); i_data = rd; i_req = 1'b1;
    wait_accept(a1);
    push_exp(rd);
    wait_done(d1);
    chk("b2b_latency1", 32'(d1 - a1), 32'(FRAME));
    i_data = 24'h780000;
    wait_accept(a2);
    chk("b2b_gap", 32'(a2 - d1), 32'd2);
    push_exp(24'h780000);
    i_req = 1'b0;
    wait_done(d2);
    chk("b2b_latency2", 32'(d2 - a2), 32'(FRAME));
    frames_ok += 2;
    repeat (20) @(negedge clk);
    #1;
    chk("b2b_no_dup", 32'(o_busy), 32'd0);
    chk("b2b_bytes", 32'(exp_q.size()), 32'd0);

    // NACK on the second byte, then a clean frame clears the flag.
    run_frame(24'($urandom), 1);
    run_frame(24'($urandom), 3);

    for (int i = 0; i < 4; i++) run_frame(24'($urandom), int'($urandom_range(0, 3)));

    // Reset during bit 5 of byte 2.
    rd = 24'($urandom); nack_sel = 3; i_data = rd; i_req = 1'b1;
    wait_accept(a1);
    i_req = 1'b0;
    push_exp(rd);
    n = 0;
    while (!(dec_byte == 1 && dec_bit == 5 && !o_scl) && n < FRAME) begin
      @(negedge clk); #1; n++;
    end
    chk("reach_bit5", 32'(dec_byte == 1 && dec_bit == 5), 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("abort_scl", 32'(o_scl), 32'd1);
    chk("abort_sda", 32'(io_sda), 32'd1);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_write_done), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (FRAME) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_idle_scl", 32'(o_scl), 32'd1);
    run_frame(24'($urandom), 3);

    chk("stop_count", 32'(stop_cnt), 32'(frames_ok));
    chk("start_count", 32'(start_cnt), 32'(frames_ok + 1));
    chk("done_count", 32'(done_cnt), 32'(frames_ok));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
